data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Data-side SRAM responder: the memory end of the `data_sram_*` interface that the EX stage drives and the MEM stage reads back through `data_sram_rdata`. It accepts one word access per cycle, applies byte-lane writes, returns read data with a registered one-cycle latency, and can insert a configurable number of wait states. During wait states it raises a stall request into the CTRL stall bus. It replaces the external data RAM in simulation and small-FPGA builds.

## Interface
- `ADDR_W`, default 12: word-index width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 0: extra cycles each access is held busy, range 0–15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `data_sram_en` input 1: access request this cycle.
- `data_sram_wen` input 4: byte write enables, bit i writes `wdata[8i+7:8i]`.
  - Any bit set makes the access a write.
  - All bits zero makes it a read.
- `data_sram_addr` input 32: byte address.
- `data_sram_wdata` input 32: store data, already lane-aligned by EX.
- `data_sram_rdata` output 32: read data returned to MEM.
- `stallreq_for_mem` output 1: asks CTRL to hold the pipeline while an access is in wait states.

## Operation
- Word index is `addr[ADDR_W+1:2]`.
  - `addr[1:0]` is ignored.
  - Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- State machine:
  - IDLE: `en=1` accepts the request.
    - A write updates the enabled byte lanes at the accepting edge.
    - A read captures the word index.
    - If `WAIT_CYCLES=0`, the block stays in IDLE and the read word is registered into `rdata` at that edge.
    - Otherwise the block loads `cnt=WAIT_CYCLES` and goes to BUSY.
  - BUSY: all inputs are ignored. CTRL holds EX, so the inputs stay stable and must not re-trigger.
    - `cnt` decrements each cycle.
    - When `cnt` reaches 1: for a read, load `rdata` from the captured index; then return to IDLE.
- `rdata` changes only when a read completes. Writes and idle cycles hold the last read value.
- `stallreq_for_mem` is asserted exactly while in BUSY, derived from state.
- Write-then-read of the same word in back-to-back accesses returns the new data. The write commits before the read's array lookup.
- Array contents are not cleared by reset. Only control state and `rdata` are reset.

## Timing
- Reset values:
  - `data_sram_rdata = 32'b0`
  - `stallreq_for_mem = 0`
  - state IDLE, `cnt = 0`
- Request accepted in cycle T:
  - Write: visible to any read accepted at T+1 or later.
  - Read with `WAIT_CYCLES=0`: `rdata` valid in cycle T+1, which lines up with the MEM stage. No stall.
  - Read with `WAIT_CYCLES=N>0`: `stallreq` is high in cycles T+1..T+N, and `rdata` is valid from cycle T+N+1, when `stallreq` is low.
- Throughput: one access every N+1 cycles.
- `rst` in BUSY: next cycle is IDLE with `stallreq=0` and `rdata=0`.
  - A pending read is dropped.
  - A write already accepted stays committed.
- `en=1` in the same cycle as `rst=1` is ignored; reset wins.

## Structure
- Add `DataSramAddrW` and `DataSramWaitMax` to `lib/defines.vh`, next to `StallBus`, as shared constants.
- Add sub-module `data_sram_array`:
  - 2^ADDR_W × 32 storage, 4 byte-lane write enables, synchronous read port, no reset.
  - Written so FPGA tools infer block RAM.
- The top level holds the FSM, wait counter, captured index/op and `rdata` register.
- The top-level `stallreq_for_mem` output is the input that feeds CTRL's stall-request logic.

## Test plan
- **Reset**: assert `rst` for 2 cycles.
  - Required: `rdata=0` and `stallreq=0`.
- **Word write/read**, `WAIT=0`: write `0x12345678` at addr `0x10` with `wen=4'b1111`, then read `0x10`.
  - Required: `rdata=0x12345678` exactly one cycle after the read is accepted.
- **Byte lanes**: over that word, write `wen=4'b0100` with `wdata=0x00AB0000`, then read.
  - Required: `0x12AB5678`.
- **Aliasing**, `ADDR_W=4`: write `0xCAFEBABE` at `0x0`, then read `0x40` and `0x3`.
  - Required: both return `0xCAFEBABE`.
- **Wait states**, `WAIT=3`: read accepted at T.
  - Required: `stallreq` is 1 in T+1..T+3 and 0 at T+4; `rdata` updates at T+4; toggling `addr` during BUSY has no effect.
- **Reset mid-operation**, `WAIT=3`: write `0x55` at addr 0, then read; assert `rst` at T+2.
  - Required: `stallreq=0` and `rdata=0` at T+3; a later read of addr 0 returns `0x55`.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared constants and types for the data-side SRAM responder.
package data_sram_responder_pkg;

    localparam int unsigned DataSramAddrW   = 12;
    localparam int unsigned DataSramWaitMax = 15;
    localparam int unsigned DataSramCntW    = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    function automatic logic is_write(input logic [3:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/data_sram_if.sv
// data_sram_* bus between the EX/MEM stages (master) and the data memory (slave).
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_array.sv
// Single-port 32-bit word store with byte-lane writes and a registered read port.
module data_sram_array #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // No reset on storage or read register so tools map this onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Memory end of the data_sram bus: one access per cycle, optional wait states,
// stall request to CTRL while busy.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DataSramAddrW,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    data_sram_if.slave   bus,
    output logic         stallreq_for_mem
);

    localparam logic NoWait = (WAIT_CYCLES == 0);
    localparam logic [DataSramCntW-1:0] WaitLoad =
        (WAIT_CYCLES > DataSramWaitMax) ? DataSramCntW'(DataSramWaitMax)
                                        : DataSramCntW'(WAIT_CYCLES);

    state_e                  state_q;
    logic [DataSramCntW-1:0] cnt_q;
    logic [ADDR_W-1:0]       idx_q;
    logic                    rd_pend_q;
    logic                    rdata_vld_q;

    logic [ADDR_W-1:0] req_idx;
    logic              req_wr;
    logic              accept;
    logic              finish_rd;
    logic [3:0]        arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [31:0]       arr_rdata;
    logic              unused_addr;

    assign req_idx     = bus.data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
    assign req_wr      = is_write(bus.data_sram_wen);
    assign accept      = !rst && (state_q == StIdle) && bus.data_sram_en;
    assign finish_rd   = !rst && (state_q == StBusy) && (cnt_q == 4'd1) && rd_pend_q;

    // Writes commit only at the accepting edge; BUSY cycles never touch the array.
    assign arr_we   = accept ? bus.data_sram_wen : 4'b0000;
    assign arr_re   = (accept && !req_wr && NoWait) || finish_rd;
    assign arr_addr = (state_q == StIdle) ? req_idx : idx_q;

    data_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (bus.data_sram_wdata),
        .rdata (arr_rdata)
    );

    // The array's read register is the rdata register; the valid flag supplies its reset value.
    assign bus.data_sram_rdata = rdata_vld_q ? arr_rdata : 32'b0;
    assign stallreq_for_mem    = (state_q == StBusy);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            rd_pend_q   <= 1'b0;
            rdata_vld_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.data_sram_en) begin
                        idx_q     <= req_idx;
                        rd_pend_q <= !req_wr;
                        if (NoWait) begin
                            if (!req_wr) begin
                                rdata_vld_q <= 1'b1;
                            end
                        end else begin
                            cnt_q   <= WaitLoad;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (rd_pend_q) begin
                            rdata_vld_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responder configurations against a word-level memory model.
module tb_data_sram_responder;

    logic clk;
    logic rst;
    logic stall_a, stall_b, stall_c;

    data_sram_if a_if ();
    data_sram_if b_if ();
    data_sram_if c_if ();

    data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_a (
        .clk (clk), .rst (rst), .bus (a_if), .stallreq_for_mem (stall_a)
    );
    data_sram_responder #(.ADDR_W(4), .WAIT_CYCLES(0)) dut_b (
        .clk (clk), .rst (rst), .bus (b_if), .stallreq_for_mem (stall_b)
    );
    data_sram_responder #(.ADDR_W(6), .WAIT_CYCLES(3)) dut_c (
        .clk (clk), .rst (rst), .bus (c_if), .stallreq_for_mem (stall_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [31:0] exp_rd [3];
    logic [31:0] mdl [int];

    function automatic int aw_of(input int d);
        return (d == 0) ? 12 : (d == 1) ? 4 : 6;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 2) ? 3 : 0;
    endfunction

    function automatic int key_of(input int d, input logic [31:0] addr);
        logic [31:0] word;
        word = (addr >> 2) & ((32'd1 << aw_of(d)) - 32'd1);
        return d * 65536 + int'(word);
    endfunction

    function automatic logic [31:0] rd(input int d);
        case (d)
            0:       return a_if.data_sram_rdata;
            1:       return b_if.data_sram_rdata;
            default: return c_if.data_sram_rdata;
        endcase
    endfunction

    function automatic logic [31:0] st(input int d);
        case (d)
            0:       return {31'b0, stall_a};
            1:       return {31'b0, stall_b};
            default: return {31'b0, stall_c};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic drive(input int d, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (d)
            0: begin
                a_if.data_sram_en = en;   a_if.data_sram_wen = wen;
                a_if.data_sram_addr = addr; a_if.data_sram_wdata = wdata;
            end
            1: begin
                b_if.data_sram_en = en;   b_if.data_sram_wen = wen;
                b_if.data_sram_addr = addr; b_if.data_sram_wdata = wdata;
            end
            default: begin
                c_if.data_sram_en = en;   c_if.data_sram_wen = wen;
                c_if.data_sram_addr = addr; c_if.data_sram_wdata = wdata;
            end
        endcase
    endtask

    // Called just after a falling edge; returns just after the falling edge of the
    // cycle in which the result is due.
    task automatic access(input int d, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          key;
        int          n;
        logic [31:0] old;
        logic [31:0] w;
        n   = wait_of(d);
        key = key_of(d, addr);
        old = exp_rd[d];
        if (wen != 4'b0) begin
            w = mdl.exists(key) ? mdl[key] : 32'hx;
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
            end
            mdl[key] = w;
        end else begin
            exp_rd[d] = mdl[key];
        end
        drive(d, 1'b1, wen, addr, wdata);
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("stall_busy", st(d), 32'd1);
            chk("rdata_hold_busy", rd(d), old);
            drive(d, 1'b1, wen, $urandom(), $urandom());
        end
        @(negedge clk);
        drive(d, 1'b0, 4'b0, addr, wdata);
        chk("stall_done", st(d), 32'd0);
        chk("rdata", rd(d), exp_rd[d]);
    endtask

    initial begin
        int          idx;
        logic [31:0] addr;
        logic [3:0]  wen;
        checks   = 0;
        failures = 0;
        for (int d = 0; d < 3; d++) begin
            exp_rd[d] = 32'b0;
            drive(d, 1'b0, 4'b0, 32'b0, 32'b0);
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_rdata", rd(d), 32'b0);
            chk("reset_stall", st(d), 32'd0);
        end

        // Word and byte-lane access, no wait states.
        access(0, 4'b1111, 32'h10, 32'h1234_5678);
        access(0, 4'b0000, 32'h10, 32'h0);
        chk("word_rd", rd(0), 32'h1234_5678);
        access(0, 4'b0100, 32'h10, 32'h00AB_0000);
        chk("write_holds_rdata", rd(0), 32'h1234_5678);
        access(0, 4'b0000, 32'h10, 32'h0);
        chk("lane_rd", rd(0), 32'h12AB_5678);

        // Address aliasing with a 16-word array.
        access(1, 4'b1111, 32'h0, 32'hCAFE_BABE);
        access(1, 4'b1111, 32'h4, 32'h1111_1111);
        access(1, 4'b0000, 32'h40, 32'h0);
        chk("alias_40", rd(1), 32'hCAFE_BABE);
        access(1, 4'b0000, 32'h4, 32'h0);
        access(1, 4'b0000, 32'h3, 32'h0);
        chk("alias_3", rd(1), 32'hCAFE_BABE);

        // Wait states: stall window and hold checked inside access.
        access(2, 4'b1111, 32'h20, 32'hA5A5_0F0F);
        access(2, 4'b0000, 32'h20, 32'h0);
        chk("wait_rd", rd(2), 32'hA5A5_0F0F);

        // Reset while a waited read is pending; a write asserted with reset must be dropped.
        access(2, 4'b1111, 32'h0, 32'h55);
        drive(2, 1'b1, 4'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_stall_t1", st(2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 4'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 4'b0, 32'h0, 32'h0);
        for (int d = 0; d < 3; d++) exp_rd[d] = 32'b0;
        chk("midrst_stall", st(2), 32'd0);
        chk("midrst_rdata_c", rd(2), 32'b0);
        chk("midrst_rdata_a", rd(0), 32'b0);
        access(2, 4'b0000, 32'h0, 32'h0);
        chk("post_rst_rd", rd(2), 32'h55);
        access(0, 4'b0000, 32'h10, 32'h0);
        chk("rst_blocks_write", rd(0), 32'h12AB_5678);

        // Randomised traffic, no wait states, random alias bits.
        for (int i = 0; i < 8; i++) access(0, 4'b1111, 32'(i) << 2, $urandom());
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(0, 7);
            addr = ($urandom() & 32'hFFFF_C003) | (32'(idx) << 2);
            wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            access(0, wen, addr, $urandom());
        end

        // Randomised traffic with wait states.
        for (int i = 0; i < 4; i++) access(2, 4'b1111, 32'(i) << 2, $urandom());
        for (int i = 0; i < 12; i++) begin
            idx  = $urandom_range(0, 3);
            addr = ($urandom() & 32'hFFFF_FF03) | (32'(idx) << 2);
            wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            access(2, wen, addr, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
